// File: rtl/param_mem_ctrl.sv
// Register-array controller: byte-enabled writes, a pipelined read path and a self-timed clear sweep.
// Read data returns RD_LATENCY cycles after accept; requests arriving while a clear sweep runs are dropped.
module param_mem_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 12,
   parameter int RD_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    write_en,
   input  logic                    read_en,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [DATA_WIDTH/8-1:0] byte_en,
   input  logic                    clear,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    ready,
   output logic                    err,
   output logic                    busy
);
   localparam int                   NB       = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   typedef struct packed {
      logic                  vld;
      logic                  err;
      logic [DATA_WIDTH-1:0] dat;
   } stage_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   stage_t                stg_q [RD_LATENCY];
   stage_t                stg_d [RD_LATENCY];

   logic in_range;
   logic rd_acc;
   logic wr_acc;

   assign in_range = {1'b0, addr} < DEPTH_W;
   assign rd_acc   = read_en && (state_q == IDLE);
   assign wr_acc   = write_en && !clear && (state_q == IDLE) && in_range;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clear) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_IDX) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (state_q == CLEAR) begin
         mem_d[cnt_q] = '0;
      end else if (wr_acc) begin
         for (int b = 0; b < NB; b++) begin
            if (byte_en[b]) mem_d[addr][8*b +: 8] = data_in[8*b +: 8];
         end
      end
   end

   // Stages only reload on valid, so the last stage holds data_out between pulses.
   always_comb begin
      stg_d        = stg_q;
      stg_d[0].vld = rd_acc;
      if (rd_acc) begin
         stg_d[0].err = !in_range;
         stg_d[0].dat = in_range ? mem_q[addr] : '0;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
         stg_d[i].vld = stg_q[i-1].vld;
         if (stg_q[i-1].vld) begin
            stg_d[i].err = stg_q[i-1].err;
            stg_d[i].dat = stg_q[i-1].dat;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         for (int i = 0; i < RD_LATENCY; i++) stg_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         for (int i = 0; i < RD_LATENCY; i++) stg_q[i] <= stg_d[i];
      end
   end

   assign ready    = stg_q[RD_LATENCY-1].vld;
   assign err      = stg_q[RD_LATENCY-1].vld & stg_q[RD_LATENCY-1].err;
   assign data_out = stg_q[RD_LATENCY-1].dat;
   assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_param_mem_ctrl.sv
// Bench for param_mem_ctrl: three instances (read latency 2, 1, 4) share one stimulus stream
// and are compared every cycle against an array model that records accepted reads by cycle.
module tb_param_mem_ctrl;
   localparam int DEPTH = 12;
   localparam int MAXC  = 8192;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_en = 1'b0;
   logic        read_en  = 1'b0;
   logic        clear    = 1'b0;
   logic [3:0]  addr     = '0;
   logic [31:0] data_in  = '0;
   logic [3:0]  byte_en  = '0;

   logic [31:0] dout [3];
   logic        rdy  [3];
   logic        er   [3];
   logic        bsy  [3];

   int checks   = 0;
   int failures = 0;

   param_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(2)) u_dut_l2 (
      .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .addr(addr),
      .data_in(data_in), .byte_en(byte_en), .clear(clear),
      .data_out(dout[0]), .ready(rdy[0]), .err(er[0]), .busy(bsy[0]));

   param_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .addr(addr),
      .data_in(data_in), .byte_en(byte_en), .clear(clear),
      .data_out(dout[1]), .ready(rdy[1]), .err(er[1]), .busy(bsy[1]));

   param_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(4)) u_dut_l4 (
      .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .addr(addr),
      .data_in(data_in), .byte_en(byte_en), .clear(clear),
      .data_out(dout[2]), .ready(rdy[2]), .err(er[2]), .busy(bsy[2]));

   always #5 clk = ~clk;

   // Reference model: storage contents, remaining clear cycles, accepted reads keyed by accept edge.
   logic [31:0] mem_m  [DEPTH];
   bit          acc_v  [MAXC];
   logic [31:0] acc_d  [MAXC];
   bit          acc_e  [MAXC];
   logic [31:0] last_d [3];
   int          clr_left = 0;
   int          cyc      = 0;

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      for (int i = 0; i < MAXC; i++) acc_v[i] = 1'b0;
      for (int k = 0; k < 3; k++) last_d[k] = '0;
      clr_left = 0;
   endtask

   task automatic check_outputs();
      for (int k = 0; k < 3; k++) begin
         int p;
         p = cyc - lat_of(k) + 1;
         if (p >= 1 && acc_v[p]) begin
            chk($sformatf("ready_l%0d", lat_of(k)), 32'(rdy[k]), 32'd1);
            chk($sformatf("data_l%0d", lat_of(k)), dout[k], acc_d[p]);
            chk($sformatf("err_l%0d", lat_of(k)), 32'(er[k]), 32'(acc_e[p]));
            last_d[k] = acc_d[p];
         end else begin
            chk($sformatf("ready_idle_l%0d", lat_of(k)), 32'(rdy[k]), 32'd0);
            chk($sformatf("err_idle_l%0d", lat_of(k)), 32'(er[k]), 32'd0);
            chk($sformatf("data_hold_l%0d", lat_of(k)), dout[k], last_d[k]);
         end
         chk($sformatf("busy_l%0d", lat_of(k)), 32'(bsy[k]), 32'(clr_left > 0));
      end
   endtask

   // Called at a falling edge: drive one cycle of inputs, update the model, check after the edge.
   task automatic step(input bit we, input bit re, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] be, input bit clr);
      int p;
      write_en = we; read_en = re; addr = a; data_in = d; byte_en = be; clear = clr;
      p = cyc + 1;
      acc_v[p] = 1'b0;
      if (clr_left > 0) begin
         clr_left--;
      end else begin
         if (re) begin
            acc_v[p] = 1'b1;
            acc_e[p] = (a >= DEPTH);
            acc_d[p] = (a < DEPTH) ? mem_m[a] : 32'h0;
         end
         if (we && !clr && a < DEPTH) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
         end
         if (clr) begin
            clr_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 4'd0, 32'h0, 4'h0, 0);
   endtask

   task automatic do_reset();
      write_en = 0; read_en = 0; clear = 0;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", 32'(rdy[k]), 32'd0);
         chk("rst_data", dout[k], 32'd0);
         chk("rst_err", 32'(er[k]), 32'd0);
         chk("rst_busy", 32'(bsy[k]), 32'd0);
      end
      model_reset();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      int rdy_cnt;
      model_reset();
      do_reset();

      for (int a = 0; a < DEPTH; a++) step(0, 1, 4'(a), 32'h0, 4'h0, 0);
      idle(4);

      step(1, 0, 4'd3, 32'hDEADBEEF, 4'b1111, 0);
      step(1, 0, 4'd3, 32'h000000AA, 4'b0001, 0);
      step(0, 1, 4'd3, 32'h0, 4'h0, 0);
      chk("rmw_l1_data", dout[1], 32'hDEADBEAA);
      chk("rmw_l2_early", 32'(rdy[0]), 32'd0);
      step(0, 0, 4'd0, 32'h0, 4'h0, 0);
      chk("rmw_l2_ready", 32'(rdy[0]), 32'd1);
      chk("rmw_l2_data", dout[0], 32'hDEADBEAA);
      idle(3);

      step(1, 0, 4'd5, 32'h11111111, 4'hF, 0);
      step(1, 1, 4'd5, 32'h22222222, 4'hF, 0);
      step(0, 1, 4'd5, 32'h0, 4'h0, 0);
      chk("rbw_old", dout[0], 32'h11111111);
      step(0, 0, 4'd0, 32'h0, 4'h0, 0);
      chk("rbw_new", dout[0], 32'h22222222);
      idle(3);

      step(0, 1, 4'd13, 32'h0, 4'h0, 0);
      step(0, 0, 4'd0, 32'h0, 4'h0, 0);
      chk("oor_err", 32'(er[0]), 32'd1);
      chk("oor_data", dout[0], 32'h0);
      step(1, 0, 4'd14, 32'hFFFFFFFF, 4'hF, 0);
      step(0, 1, 4'd14, 32'h0, 4'h0, 0);
      idle(4);

      for (int a = 0; a < DEPTH; a++) step(1, 0, 4'(a), $urandom, 4'hF, 0);
      busy_cnt = 0;
      step(0, 1, 4'd4, 32'h0, 4'h0, 1);
      busy_cnt += int'(bsy[0]);
      step(1, 1, 4'd2, 32'h5A5A5A5A, 4'hF, 0);
      busy_cnt += int'(bsy[0]);
      for (int i = 0; i < 13; i++) begin
         step(0, 0, 4'd0, 32'h0, 4'h0, (i == 3));
         busy_cnt += int'(bsy[0]);
      end
      chk("clear_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
      for (int a = 0; a < DEPTH; a++) step(0, 1, 4'(a), 32'h0, 4'h0, 0);
      idle(4);

      for (int a = 0; a < 4; a++) step(1, 0, 4'(a), $urandom | 32'h1, 4'hF, 0);
      for (int a = 0; a < 4; a++) step(0, 1, 4'(a), 32'h0, 4'h0, 0);
      do_reset();
      rdy_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 4'd0, 32'h0, 4'h0, 0);
         rdy_cnt += int'(rdy[0]) + int'(rdy[1]) + int'(rdy[2]);
      end
      chk("no_ready_after_rst", 32'(rdy_cnt), 32'd0);

      for (int n = 0; n < 1500 && cyc < MAXC - 50; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 5,
                 4'($urandom_range(0, 15)), $urandom, 4'($urandom),
                 $urandom_range(0, 59) == 0);
         end
      end
      idle(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
